// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a per-register busy scoreboard.
//
// Two combinational read ports, two write ports (wr1 wins on a shared
// address) and a busy bit per register. An issue marks its destination busy
// through busy_set_en/busy_set_addr; a write-back on either write port clears
// the busy bit of its address. A set and a clear of the same address in one
// cycle leave the register busy, since the newly issued producer is still
// outstanding. busy_count is a registered population count of the busy
// vector.
//
// Parameters:
//   DATA_W   - register width
//   ADDR_W   - address width, depth = 2**ADDR_W
//   ZERO_REG - 1: register 0 reads 0 and ignores writes and busy_set
//   BYPASS   - 1: same-cycle write data and busy updates appear on reads
//
// Ports:
//   clk, reset            - clock (rising edge), async active-high reset
//   clear                 - synchronous clear of data, busy bits, busy_count
//   rd_addr_a/b           - read addresses
//   rd_data_a/b           - read data (combinational)
//   rd_busy_a/b           - addressed register has a pending producer
//   wr0_*/wr1_*           - write ports (enable, address, data)
//   busy_set_en/addr      - mark a destination as pending
//   busy_count            - number of busy registers (registered)
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              busy_set_en,
    input  logic [ADDR_W-1:0] busy_set_addr,
    output logic [ADDR_W:0]   busy_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_upd;   // busy vector after this cycle's set/clears
    logic [DEPTH-1:0]  busy_nxt;   // busy_upd with clear applied
    logic              wr0_v;
    logic              wr1_v;
    logic              set_v;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + (ADDR_W+1)'(v[i]);
        end
        return cnt;
    endfunction

    // Register 0 is never written under ZERO_REG, so it stays at its reset
    // value of 0 and its storage collapses to a constant.
    always_comb begin
        wr0_v = wr0_en;
        wr1_v = wr1_en;
        set_v = busy_set_en;
        if (ZERO_REG != 0) begin
            if (wr0_addr == '0)      wr0_v = 1'b0;
            if (wr1_addr == '0)      wr1_v = 1'b0;
            if (busy_set_addr == '0) set_v = 1'b0;
        end
    end

    // Clears are applied before the set so that set wins on a shared address.
    always_comb begin
        busy_upd = busy_q;
        if (wr0_v) busy_upd[wr0_addr] = 1'b0;
        if (wr1_v) busy_upd[wr1_addr] = 1'b0;
        if (set_v) busy_upd[busy_set_addr] = 1'b1;
        busy_nxt = clear ? '0 : busy_upd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy_q     <= '0;
            busy_count <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy_q     <= '0;
            busy_count <= '0;
        end else begin
            // wr1 is assigned last so it wins when both ports hit one address.
            if (wr0_v) regs[wr0_addr] <= wr0_data;
            if (wr1_v) regs[wr1_addr] <= wr1_data;
            busy_q     <= busy_nxt;
            busy_count <= popcount(busy_nxt);
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        rd_busy_a = busy_q[rd_addr_a];
        if (BYPASS != 0) begin
            if (wr1_v && (wr1_addr == rd_addr_a))      rd_data_a = wr1_data;
            else if (wr0_v && (wr0_addr == rd_addr_a)) rd_data_a = wr0_data;
            rd_busy_a = busy_upd[rd_addr_a];
        end
        if ((ZERO_REG != 0) && (rd_addr_a == '0)) begin
            rd_data_a = '0;
            rd_busy_a = 1'b0;
        end
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        rd_busy_b = busy_q[rd_addr_b];
        if (BYPASS != 0) begin
            if (wr1_v && (wr1_addr == rd_addr_b))      rd_data_b = wr1_data;
            else if (wr0_v && (wr0_addr == rd_addr_b)) rd_data_b = wr0_data;
            rd_busy_b = busy_upd[rd_addr_b];
        end
        if ((ZERO_REG != 0) && (rd_addr_b == '0)) begin
            rd_data_b = '0;
            rd_busy_b = 1'b0;
        end
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the execution-cycle datapath, with two read ports, two write ports and a per-register busy scoreboard. Each register has a busy bit that is set when an instruction issues with that register as its destination and cleared when the result is written back. This lets the issue stage detect RAW hazards without a separate scoreboard block. Optional same-cycle write-to-read bypass and optional hardwired-zero register 0 keep it drop-in compatible with the single-write register file.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes and busy-set
- BYPASS, 1, 1: same-cycle write data and busy-clear visible on read ports

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all registers, busy bits and busy_count
- clear  in  1  synchronous clear of all registers, busy bits and busy_count
- rd_addr_a, rd_addr_b  in  ADDR_W  read addresses
- rd_data_a, rd_data_b  out  DATA_W  read data (combinational)
- rd_busy_a, rd_busy_b  out  1  addressed register has a pending producer
- wr0_en, wr1_en  in  1  write enables
- wr0_addr, wr1_addr  in  ADDR_W  write addresses
- wr0_data, wr1_data  in  DATA_W  write data
- busy_set_en  in  1  mark busy_set_addr as pending (issue)
- busy_set_addr  in  ADDR_W  destination being issued
- busy_count  out  ADDR_W+1  number of registers currently busy (registered)

## Operation
- Storage: 2**ADDR_W × DATA_W registers and 2**ADDR_W busy bits. With ZERO_REG=1, entry 0 has no storage.
- Write: at posedge, each enabled port writes its data.
  - Same address on wr0 and wr1: wr1 wins.
- Busy clear: every enabled write clears the busy bit of its address.
- Busy set: busy_set_en sets the busy bit of busy_set_addr.
  - When set and clear hit the same address in the same cycle, set wins, because the new producer is still outstanding.
- ZERO_REG=1, address 0:
  - Writes and busy_set are ignored.
  - rd_data reads 0 and rd_busy reads 0.
- Read, BYPASS=0: rd_data is the stored value and rd_busy is the stored busy bit.
- Read, BYPASS=1: if an enabled write targets rd_addr this cycle (excluding address 0 under ZERO_REG):
  - rd_data returns the incoming data, with wr1 taking priority over wr0.
  - rd_busy returns 0, unless busy_set_en targets the same address this cycle, in which case rd_busy returns 1.
- busy_count:
  - Register updated at posedge to the population count of the next-state busy vector.
  - It equals the popcount of the busy bits visible the cycle after the update.
  - Range 0..2**ADDR_W (0..2**ADDR_W−1 when ZERO_REG=1).
- Clear priority: reset > clear > writes/busy_set. A cycle with clear high discards all writes and busy_set of that cycle.
- Reset and clear values: all registers 0, all busy bits 0, busy_count 0.
  - Read outputs are combinational and follow immediately, e.g. rd_data 0 and rd_busy 0 for any address.

## Timing
- Read latency: 0 cycles (combinational from rd_addr and the state).
- Write latency:
  - Data is visible through storage on the first read after the posedge.
  - With BYPASS=1, it is also visible in the same cycle.
- busy_set → rd_busy:
  - BYPASS=0: high from the cycle after the posedge.
  - BYPASS=1: high in the same cycle as well.
- busy_count lags the busy vector by 0 cycles at the register boundary; it is registered and never combinationally dependent on inputs.
- Reset asserted mid-operation: state clears asynchronously, regardless of clk. The first write after deassertion is accepted on the first posedge with reset low.
- No handshake: all inputs are sampled every posedge. The block never stalls.

## Test plan
- Reset then read all addresses → rd_data 0, rd_busy 0, busy_count 0. Then write 0xDEADBEEF to r5 via wr0 → next cycle rd_data_a(r5) = 0xDEADBEEF.
- wr0 and wr1 both write r7 (0x11111111 and 0x22222222) in one cycle → r7 = 0x22222222. With BYPASS=1, rd_data_b(r7) shows 0x22222222 in the same cycle.
- busy_set r3, next cycle → rd_busy_a(r3) = 1 and busy_count = 1. Then wr1 writes r3 = 0xA5 → busy clears and busy_count = 0.
- busy_set r9 and wr0 to r9 in the same cycle (r9 previously busy) → r9 data updated, busy stays 1, busy_count unchanged.
- ZERO_REG=1: wr0 0xFFFFFFFF to r0 and busy_set r0 → rd_data 0, rd_busy 0, busy_count 0. Then clear asserted together with a write to r4 → r4 = 0 and all busy bits 0.
- Set busy on all 31 non-zero registers over consecutive cycles → busy_count reaches 31. Then assert reset mid-cycle → all outputs 0 before the next posedge.
